// File: rtl/alu_pkg.sv
// Shared types for the ALU operation issuer.
// Opcodes match the 2-to-4 decoder outputs D0..D3.
package alu_pkg;

   localparam int ALU_DATA_W = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_RESP
   } iss_state_e;

   typedef struct packed {
      logic [1:0]            op;
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
   } alu_req_t;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Request, decoder/ALU and response signals of the issuer.
// slave is the issuer side, master the surrounding system.
interface alu_op_issuer_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              sel0;
   logic              sel1;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W:0]   alu_result;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W:0]   out_result;
   logic [1:0]        out_op;
   logic              busy;

   modport slave (
      input  in_valid, in_op, in_a, in_b,
      input  alu_result, out_ready,
      output in_ready, sel0, sel1, op_a, op_b,
      output out_valid, out_result, out_op, busy
   );

   modport master (
      output in_valid, in_op, in_a, in_b,
      output alu_result, out_ready,
      input  in_ready, sel0, sel1, op_a, op_b,
      input  out_valid, out_result, out_op, busy
   );
endinterface

// File: rtl/alu_op_fifo.sv
// Request FIFO: power-of-two depth, pointers wrap naturally.
// Push when full and pop when empty are ignored.
module alu_op_fifo #(
   parameter int W     = 18,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q];

   // storage needs no reset; occupancy is tracked by the pointers
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= wdata_i;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
      end
endmodule

// File: rtl/alu_op_issuer.sv
// Issues buffered ALU requests one at a time through the
// operation decoder and returns the settled ALU result.
module alu_op_issuer
   import alu_pkg::*;
#(
   parameter int DATA_W     = ALU_DATA_W,
   parameter int DEPTH      = 4,
   parameter int SETTLE_CYC = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_op_issuer_if.slave bus
);
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int REQ_W = 2 + 2 * DATA_W;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

   if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("SETTLE_CYC must be >= 1");
   end

   typedef struct packed {
      logic [1:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } req_t;

   req_t              wr_req;
   req_t              head;
   logic              full;
   logic              empty;
   logic              pop;

   iss_state_e        state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              vld_q, vld_d;
   logic [DATA_W:0]   res_q, res_d;
   logic [1:0]        rop_q, rop_d;

   assign wr_req = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};

   alu_op_fifo #(
      .W     (REQ_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (bus.in_valid),
      .wdata_i (wr_req),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign bus.in_ready   = !full;
   assign bus.sel0       = sel_q[0];
   assign bus.sel1       = sel_q[1];
   assign bus.op_a       = opa_q;
   assign bus.op_b       = opb_q;
   assign bus.out_valid  = vld_q;
   assign bus.out_result = res_q;
   assign bus.out_op     = rop_q;
   assign bus.busy       = (state_q != ST_IDLE) || !empty;

   // next state: issue, settle countdown, response hold
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      cnt_d   = cnt_q;
      vld_d   = vld_q;
      res_d   = res_q;
      rop_d   = rop_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty) pop = 1'b1;
         end
         ST_DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               vld_d   = 1'b1;
               res_d   = bus.alu_result;
               rop_d   = sel_q;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.out_ready) begin
               vld_d   = 1'b0;
               state_d = ST_IDLE;
               if (!empty) pop = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         sel_d   = head.op;
         opa_d   = head.a;
         opb_d   = head.b;
         cnt_d   = CNT_INIT;
         state_d = ST_DRIVE;
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         res_q   <= '0;
         rop_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         res_q   <= res_d;
         rop_q   <= rop_d;
      end
endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a model ALU and
// an in-order response scoreboard.
module tb_alu_op_issuer;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_op_issuer_if #(.DATA_W(8)) b1 ();
   alu_op_issuer_if #(.DATA_W(8)) b3 ();

   alu_op_issuer #(
      .DATA_W(8), .DEPTH(4), .SETTLE_CYC(1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1)
   );

   alu_op_issuer #(
      .DATA_W(8), .DEPTH(4), .SETTLE_CYC(3)
   ) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(b3)
   );

   function automatic logic [8:0] alu_f(
      input logic [1:0] op,
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [8:0] r;
      r = '0;
      case (op)
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         OP_SUB:  r = {1'b0, a} - {1'b0, b};
         OP_AND:  r = {1'b0, a & b};
         default: r = {1'b0, a | b};
      endcase
      return r;
   endfunction

   logic [8:0] noise = '0;

   assign b1.alu_result =
      alu_f({b1.sel1, b1.sel0}, b1.op_a, b1.op_b) ^ noise;
   assign b3.alu_result =
      alu_f({b3.sel1, b3.sel0}, b3.op_a, b3.op_b);

   int checks = 0;
   int failures = 0;
   int acc_cnt = 0;
   int resp_cnt = 0;
   bit ordy = 1'b0;
   logic [17:0] req_q[$];
   logic [10:0] exp_q[$];
   logic [10:0] exp3_q[$];

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // one cycle on dut1: drive, score handshakes, advance
   task automatic step();
      logic [17:0] r;
      logic [10:0] e;
      r = (req_q.size() > 0) ? req_q[0] : '0;
      b1.in_valid = (req_q.size() > 0);
      {b1.in_op, b1.in_a, b1.in_b} = r;
      b1.out_ready = ordy;
      if (b1.out_valid && b1.out_ready) begin
         chk("resp_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("resp_op", 32'(b1.out_op), 32'(e[10:9]));
            chk("resp_result", 32'(b1.out_result), 32'(e[8:0]));
            resp_cnt++;
         end
      end
      if (b1.in_valid && b1.in_ready) begin
         exp_q.push_back({r[17:16], alu_f(r[17:16], r[15:8], r[7:0])});
         void'(req_q.pop_front());
         acc_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic drain(input int max, input string tag);
      int n;
      n = 0;
      while ((req_q.size() > 0 || exp_q.size() > 0) && n < max) begin
         step();
         n++;
      end
      chk(tag, 32'(n < max), 32'd1);
   endtask

   task automatic push3(input logic [1:0] op, input logic [7:0] a);
      b3.in_valid = 1'b1;
      b3.in_op = op;
      b3.in_a = a;
      b3.in_b = 8'h21;
      chk("d3_in_ready", 32'(b3.in_ready), 32'd1);
      @(negedge clk);
      b3.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int w, last, cyc, got, seen, r0;
      logic [10:0] e;
      b1.in_valid = 0; b1.in_op = 0; b1.in_a = 0; b1.in_b = 0;
      b1.out_ready = 0;
      b3.in_valid = 0; b3.in_op = 0; b3.in_a = 0; b3.in_b = 0;
      b3.out_ready = 0;
      repeat (2) @(negedge clk);

      chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
      chk("rst_out_result", 32'(b1.out_result), 32'd0);
      chk("rst_out_op", 32'(b1.out_op), 32'd0);
      chk("rst_busy", 32'(b1.busy), 32'd0);
      chk("rst_in_ready", 32'(b1.in_ready), 32'd1);
      chk("rst_sel", 32'({b1.sel1, b1.sel0}), 32'd0);
      chk("rst_op_a", 32'(b1.op_a), 32'd0);
      chk("rst_op_b", 32'(b1.op_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // latency: request accepted at edge k
      b1.in_valid = 1'b1;
      b1.in_op = OP_SUB; b1.in_a = 8'h05; b1.in_b = 8'h03;
      @(negedge clk);
      b1.in_valid = 1'b0;
      chk("lat_busy_k", 32'(b1.busy), 32'd1);
      chk("lat_sel_k", 32'({b1.sel1, b1.sel0}), 32'd0);
      @(negedge clk);
      chk("lat_sel_k1", 32'({b1.sel1, b1.sel0}), 32'd1);
      chk("lat_op_a", 32'(b1.op_a), 32'h05);
      chk("lat_op_b", 32'(b1.op_b), 32'h03);
      chk("lat_valid_k1", 32'(b1.out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid_k2", 32'(b1.out_valid), 32'd1);
      chk("lat_result", 32'(b1.out_result), 32'h002);
      chk("lat_op", 32'(b1.out_op), 32'd1);
      b1.out_ready = 1'b1;
      @(negedge clk);
      chk("lat_valid_drop", 32'(b1.out_valid), 32'd0);
      chk("lat_idle", 32'(b1.busy), 32'd0);

      // backpressure: 6 requests, responses stalled
      ordy = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 6; i++)
         req_q.push_back({2'(i), 8'(8'h10 + i * 7), 8'(i * 3)});
      repeat (10) step();
      chk("bp_accepted", 32'(acc_cnt), 32'd5);
      chk("bp_in_ready", 32'(b1.in_ready), 32'd0);
      chk("bp_out_valid", 32'(b1.out_valid), 32'd1);
      chk("bp_pending", 32'(req_q.size()), 32'd1);
      ordy = 1'b1;
      drain(60, "bp_drain");
      chk("bp_all_accepted", 32'(acc_cnt), 32'd6);

      // response stall while the ALU output wanders
      ordy = 1'b0;
      req_q.push_back({OP_ADD, 8'hC8, 8'h64});
      w = 0;
      while (!b1.out_valid && w < 10) begin
         step();
         w++;
      end
      chk("stall_wait", 32'(w < 10), 32'd1);
      for (int k = 0; k < 5; k++) begin
         noise = 9'($urandom_range(1, 511));
         step();
         chk("stall_valid", 32'(b1.out_valid), 32'd1);
         chk("stall_hold", 32'(b1.out_result), 32'h12C);
      end
      noise = '0;
      ordy = 1'b1;
      drain(20, "stall_drain");

      // FIFO pointer wrap
      r0 = resp_cnt;
      for (int i = 0; i < 10; i++)
         req_q.push_back({2'(i), 8'(i), 8'(8'hF0 - i)});
      drain(80, "wrap_drain");
      chk("wrap_count", 32'(resp_cnt - r0), 32'd10);

      // streaming on the 3-cycle settle instance
      b3.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp3_q.push_back({2'(i),
            alu_f(2'(i), 8'(8'h40 + i * 5), 8'h21)});
         push3(2'(i), 8'(8'h40 + i * 5));
      end
      last = -1; cyc = 0; got = 0;
      while (got < 4 && cyc < 40) begin
         if (b3.out_valid) begin
            e = exp3_q.pop_front();
            chk("st_op", 32'(b3.out_op), 32'(e[10:9]));
            chk("st_result", 32'(b3.out_result), 32'(e[8:0]));
            chk("st_sel", 32'({b3.sel1, b3.sel0}), 32'(e[10:9]));
            if (last >= 0) chk("st_gap", 32'(cyc - last), 32'd4);
            last = cyc;
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("st_count", 32'(got), 32'd4);

      // reset in DRIVE with two requests queued
      for (int i = 0; i < 3; i++) push3(OP_OR, 8'(i));
      chk("mid_busy", 32'(b3.busy), 32'd1);
      chk("mid_sel", 32'({b3.sel1, b3.sel0}), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(b3.out_valid), 32'd0);
      chk("ar_sel", 32'({b3.sel1, b3.sel0}), 32'd0);
      chk("ar_op_a", 32'(b3.op_a), 32'd0);
      chk("ar_out_result", 32'(b3.out_result), 32'd0);
      chk("ar_busy", 32'(b3.busy), 32'd0);
      chk("ar_in_ready", 32'(b3.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (b3.out_valid || b3.busy) seen++;
      end
      chk("ar_no_stale", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
